// File: rtl/tinyqv_serial_core.sv
// Nibble-serial RV32E execution core: register file, serial ALU, branch/jump
// resolution and load/store address/data sequencing, one nibble per cycle.
module tinyqv_serial_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  imm,
  input  logic [11:0] imm_lo,
  input  logic        is_load,
  input  logic        is_alu_imm,
  input  logic        is_auipc,
  input  logic        is_store,
  input  logic        is_alu_reg,
  input  logic        is_lui,
  input  logic        is_branch,
  input  logic        is_jalr,
  input  logic        is_jal,
  input  logic        is_system,
  input  logic        stall_txn,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  mem_op,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [3:0]  rd,
  input  logic [2:0]  counter,
  input  logic [3:0]  pc,
  input  logic [3:0]  next_pc,
  input  logic [3:0]  data_in,
  input  logic        load_data_ready,
  output logic [3:0]  data_out,
  output logic [27:0] addr_out,
  output logic        address_ready,
  output logic        instr_complete,
  output logic        branch
);
  typedef enum logic {EXEC, WAIT_DATA} state_t;
  state_t state_q, state_d;

  logic [31:0] regs [0:15];
  logic [31:0] rs1_live, rs2_live, rs1_snap, rs2_snap, rs1_full, rs2_full;
  logic [31:0] imm_full, cmp_b, sh_left, sh_right;
  logic signed [31:0] sh_arith;
  logic [4:0]  nib_idx, shamt;
  logic [3:0]  a_nib, b_raw, b_nib, sum, alu_nib, load_nib, wr_nib, addr_nib;
  logic        is_sub, cin, cout, carry_q, lt_s, lt_u, eq, taken;
  logic        writes_rd, addr_class, other_class, wr_en;
  logic        data_round, data_round_q, sign_q, load_in_range;

  assign nib_idx  = {counter, 2'b00};
  assign rs1_live = (rs1 == 4'd0) ? 32'd0 : regs[rs1];
  assign rs2_live = (rs2 == 4'd0) ? 32'd0 : regs[rs2];

  // Full-width consumers (shifts, compares) see the operands as they were at
  // nibble 0, so an rd that aliases rs1/rs2 cannot corrupt later nibbles.
  always_ff @(posedge clk) begin
    if (counter == 3'd0) begin
      rs1_snap <= rs1_live;
      rs2_snap <= rs2_live;
    end
  end
  assign rs1_full = (counter == 3'd0) ? rs1_live : rs1_snap;
  assign rs2_full = (counter == 3'd0) ? rs2_live : rs2_snap;

  assign writes_rd   = is_alu_reg | is_alu_imm | is_lui | is_auipc | is_jal | is_jalr;
  assign other_class = writes_rd | is_branch | is_system;
  assign addr_class  = is_load | is_store | is_jal | is_jalr | is_branch;

  assign is_sub = (is_alu_reg | is_alu_imm) & ((alu_op == 4'b1000) | (alu_op[2:1] == 2'b01));
  assign a_nib  = (is_auipc | is_jal | is_branch) ? pc : rs1_live[nib_idx +: 4];
  assign b_raw  = is_alu_reg ? rs2_live[nib_idx +: 4] : imm;
  assign b_nib  = is_sub ? ~b_raw : b_raw;
  assign cin    = (counter == 3'd0) ? is_sub : carry_q;
  assign {cout, sum} = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, cin};

  assign imm_full = {{20{imm_lo[11]}}, imm_lo};
  assign cmp_b    = is_alu_imm ? imm_full : rs2_full;
  assign lt_s     = $signed(rs1_full) < $signed(cmp_b);
  assign lt_u     = rs1_full < cmp_b;
  assign eq       = rs1_full == cmp_b;

  assign shamt    = is_alu_reg ? rs2_full[4:0] : imm_lo[4:0];
  assign sh_left  = rs1_full << shamt;
  assign sh_arith = $signed(rs1_full) >>> shamt;
  assign sh_right = alu_op[3] ? sh_arith : (rs1_full >> shamt);

  always_comb begin
    taken = 1'b0;
    case (alu_op[2:0])
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      3'b100:  taken = lt_s;
      3'b101:  taken = ~lt_s;
      3'b110:  taken = lt_u;
      3'b111:  taken = ~lt_u;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_nib = sum;
    case (alu_op[2:0])
      3'b001:  alu_nib = sh_left[nib_idx +: 4];
      3'b010:  alu_nib = {3'b000, lt_s & (counter == 3'd0)};
      3'b011:  alu_nib = {3'b000, lt_u & (counter == 3'd0)};
      3'b100:  alu_nib = a_nib ^ b_raw;
      3'b101:  alu_nib = sh_right[nib_idx +: 4];
      3'b110:  alu_nib = a_nib | b_raw;
      3'b111:  alu_nib = a_nib & b_raw;
      default: alu_nib = sum;
    endcase
  end

  // Sign of a byte/half load is the MSB of its last data nibble.
  assign load_in_range = mem_op[1] | (mem_op[0] ? (counter < 3'd4) : (counter < 3'd2));
  assign load_nib = load_in_range ? data_in : (mem_op[2] ? 4'h0 : {4{sign_q}});
  assign data_round = (counter == 3'd0) ? load_data_ready : data_round_q;

  assign wr_nib = (state_q == WAIT_DATA) ? load_nib :
                  is_lui                 ? imm      :
                  is_auipc               ? sum      :
                  (is_jal | is_jalr)     ? next_pc  : alu_nib;
  assign addr_nib = (is_jalr && counter == 3'd0) ? {sum[3:1], 1'b0} : sum;

  always_comb begin
    state_d        = state_q;
    wr_en          = 1'b0;
    data_out       = 4'h0;
    address_ready  = 1'b0;
    instr_complete = 1'b0;
    branch         = 1'b0;
    if (rst) begin
      state_d = EXEC;
    end else begin
      case (state_q)
        EXEC: begin
          wr_en = writes_rd;
          if (writes_rd) data_out = wr_nib;
          else if (is_store) data_out = rs2_live[nib_idx +: 4];
          if (counter == 3'd7) begin
            if (is_load || is_store) begin
              if (!stall_txn) begin
                address_ready = 1'b1;
                if (is_load) state_d = WAIT_DATA;
                else instr_complete = 1'b1;
              end
            end else if (other_class) begin
              instr_complete = 1'b1;
              branch = is_jal | is_jalr | (is_branch & taken);
            end
          end
        end
        WAIT_DATA: begin
          if (data_round) begin
            wr_en    = 1'b1;
            data_out = wr_nib;
            if (counter == 3'd7) begin
              instr_complete = 1'b1;
              state_d        = EXEC;
            end
          end
        end
        default: state_d = EXEC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EXEC;
      carry_q      <= 1'b0;
      data_round_q <= 1'b0;
      addr_out     <= 28'd0;
    end else begin
      state_q      <= state_d;
      carry_q      <= cout;
      data_round_q <= data_round;
      if (state_q == EXEC && addr_class && counter != 3'd7)
        addr_out[nib_idx +: 4] <= addr_nib;
    end
  end

  always_ff @(posedge clk) begin
    if (load_in_range) sign_q <= data_in[3];
    if (wr_en && rd != 4'd0) regs[rd][nib_idx +: 4] <= wr_nib;
  end
endmodule

// File: tb/tb_tinyqv_serial_core.sv
// Scoreboard bench for tinyqv_serial_core: directed instruction rounds push
// expected retire events; a negedge monitor assembles data_out and compares.
module tb_tinyqv_serial_core;
  localparam int C_NONE = 0, C_LOAD = 1, C_ALUI = 2, C_AUIPC = 3, C_STORE = 4, C_ALUR = 5;
  localparam int C_LUI = 6, C_BR = 7, C_JALR = 8, C_JAL = 9, C_SYS = 10;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] imm, alu_op, rs1, rs2, rd, pc, next_pc, data_in, data_out;
  logic [11:0] imm_lo;
  logic is_load, is_alu_imm, is_auipc, is_store, is_alu_reg, is_lui;
  logic is_branch, is_jalr, is_jal, is_system, stall_txn, load_data_ready;
  logic [2:0] mem_op, counter;
  logic [27:0] addr_out;
  logic address_ready, instr_complete, branch;

  always #5 clk = ~clk;

  tinyqv_serial_core dut (
    .clk(clk), .rst(rst), .imm(imm), .imm_lo(imm_lo),
    .is_load(is_load), .is_alu_imm(is_alu_imm), .is_auipc(is_auipc), .is_store(is_store),
    .is_alu_reg(is_alu_reg), .is_lui(is_lui), .is_branch(is_branch), .is_jalr(is_jalr),
    .is_jal(is_jal), .is_system(is_system), .stall_txn(stall_txn), .alu_op(alu_op),
    .mem_op(mem_op), .rs1(rs1), .rs2(rs2), .rd(rd), .counter(counter), .pc(pc),
    .next_pc(next_pc), .data_in(data_in), .load_data_ready(load_data_ready),
    .data_out(data_out), .addr_out(addr_out), .address_ready(address_ready),
    .instr_complete(instr_complete), .branch(branch)
  );

  typedef struct {
    bit cmp; bit br; bit ar; bit ca; logic [27:0] addr; bit cd; logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int n_checks = 0;
  int n_err = 0;
  logic [31:0] imm_v, pc_v, npc_v, din_v, obs;
  bit ldr_v, stall_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops one expectation per retire/address/branch strobe
  always @(negedge clk) begin
    if (!rst) begin
      obs[{counter, 2'b00} +: 4] = data_out;
      if (counter != 3'd7) begin
        chk("strobe_off_c7", 32'({address_ready, instr_complete, branch}), 32'd0);
      end else if (address_ready || instr_complete || branch) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 32'({address_ready, instr_complete, branch}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("instr_complete", 32'(instr_complete), 32'(e.cmp));
          chk("branch", 32'(branch), 32'(e.br));
          chk("address_ready", 32'(address_ready), 32'(e.ar));
          if (e.ca) chk("addr_out", 32'(addr_out), 32'(e.addr));
          if (e.cd) chk("data_out_word", obs, e.data);
        end
      end
    end
  end

  task automatic set_instr(input int cls, input logic [3:0] op, input logic [2:0] mop,
                           input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] d,
                           input logic [31:0] iv);
    is_load = (cls == C_LOAD);   is_alu_imm = (cls == C_ALUI); is_auipc = (cls == C_AUIPC);
    is_store = (cls == C_STORE); is_alu_reg = (cls == C_ALUR); is_lui = (cls == C_LUI);
    is_branch = (cls == C_BR);   is_jalr = (cls == C_JALR);    is_jal = (cls == C_JAL);
    is_system = (cls == C_SYS);
    alu_op = op; mem_op = mop; rs1 = r1; rs2 = r2; rd = d;
    imm_v = iv; imm_lo = iv[11:0];
  endtask

  task automatic expect_evt(input bit cmp, input bit br, input bit ar, input bit ca,
                            input logic [27:0] addr, input bit cd, input logic [31:0] data);
    exp_t t;
    t.cmp = cmp; t.br = br; t.ar = ar; t.ca = ca; t.addr = addr; t.cd = cd; t.data = data;
    exp_q.push_back(t);
  endtask

  // One 8-cycle round; rst is high from counter rst_from onward. quiet rounds
  // must show no strobes at counter 7 (and zeroed outputs when reset).
  task automatic do_round(input int rst_from, input bit quiet);
    for (int c = 0; c < 8; c++) begin
      counter = 3'(c);
      imm = imm_v[c*4 +: 4];
      pc = pc_v[c*4 +: 4];
      next_pc = npc_v[c*4 +: 4];
      data_in = din_v[c*4 +: 4];
      load_data_ready = (c == 0) && ldr_v;
      stall_txn = stall_v;
      rst = (c >= rst_from);
      @(negedge clk);
      if (c == 7 && quiet) begin
        chk("quiet_strobes", 32'({address_ready, instr_complete, branch}), 32'd0);
        if (rst_from < 8) begin
          chk("reset_data_out", 32'(data_out), 32'd0);
          chk("reset_addr_out", 32'(addr_out), 32'd0);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic alu(input int cls, input logic [3:0] op, input logic [3:0] r1,
                     input logic [3:0] r2, input logic [3:0] d, input logic [31:0] iv,
                     input logic [31:0] res);
    set_instr(cls, op, 3'd0, r1, r2, d, iv);
    expect_evt(1, 0, 0, 0, 28'd0, 1, res);
    do_round(8, 0);
  endtask

  task automatic load(input logic [2:0] mop, input logic [31:0] off, input logic [31:0] din,
                      input int nwait, input logic [31:0] res);
    set_instr(C_LOAD, 4'd0, mop, 4'd2, 4'd0, 4'd9, off);
    expect_evt(0, 0, 1, 1, 28'(32'h1000 + off), 1, 32'd0);
    ldr_v = 0;
    do_round(8, 0);
    for (int i = 0; i < nwait; i++) do_round(8, 1);
    din_v = din;
    ldr_v = 1;
    expect_evt(1, 0, 0, 1, 28'(32'h1000 + off), 1, res);
    do_round(8, 0);
    ldr_v = 0;
  endtask

  initial begin
    rst = 1'b1;
    set_instr(C_NONE, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0, 32'd0);
    pc_v = 32'd0; npc_v = 32'd4; din_v = 32'd0; ldr_v = 0; stall_v = 0;
    do_round(0, 1);
    do_round(0, 1);

    alu(C_ALUI, 4'b0000, 4'd0, 4'd0, 4'd1, 32'd5, 32'd5);
    alu(C_ALUI, 4'b0000, 4'd0, 4'd0, 4'd2, 32'd3, 32'd3);
    alu(C_ALUR, 4'b0000, 4'd1, 4'd2, 4'd3, 32'd0, 32'd8);
    alu(C_ALUR, 4'b1000, 4'd1, 4'd2, 4'd4, 32'd0, 32'd2);
    alu(C_ALUR, 4'b0000, 4'd3, 4'd4, 4'd10, 32'd0, 32'hA);
    alu(C_LUI,  4'b0000, 4'd0, 4'd0, 4'd5, 32'h12345000, 32'h12345000);
    alu(C_ALUR, 4'b0000, 4'd5, 4'd0, 4'd10, 32'd0, 32'h12345000);
    pc_v = 32'h100;
    alu(C_AUIPC, 4'b0000, 4'd0, 4'd0, 4'd6, 32'h1000, 32'h1100);
    pc_v = 32'd0;

    alu(C_ALUI, 4'b0000, 4'd0, 4'd0, 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    alu(C_ALUI, 4'b0000, 4'd0, 4'd0, 4'd2, 32'd1, 32'd1);
    alu(C_ALUR, 4'b0010, 4'd1, 4'd2, 4'd3, 32'd0, 32'd1);
    alu(C_ALUR, 4'b0011, 4'd1, 4'd2, 4'd4, 32'd0, 32'd0);
    alu(C_ALUI, 4'b0011, 4'd2, 4'd0, 4'd3, 32'hFFFFFFFF, 32'd1);
    alu(C_ALUI, 4'b1101, 4'd1, 4'd0, 4'd7, 32'h404, 32'hFFFFFFFF);
    alu(C_ALUI, 4'b0101, 4'd1, 4'd0, 4'd7, 32'd4, 32'h0FFFFFFF);
    alu(C_ALUI, 4'b0001, 4'd2, 4'd0, 4'd8, 32'd31, 32'h80000000);
    alu(C_ALUR, 4'b0001, 4'd2, 4'd2, 4'd8, 32'd0, 32'd2);
    alu(C_ALUR, 4'b0100, 4'd1, 4'd2, 4'd9, 32'd0, 32'hFFFFFFFE);
    alu(C_ALUR, 4'b0111, 4'd1, 4'd2, 4'd9, 32'd0, 32'd1);
    alu(C_ALUI, 4'b0110, 4'd2, 4'd0, 4'd9, 32'hF0, 32'hF1);
    alu(C_SYS,  4'b0000, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0);

    pc_v = 32'h200;
    set_instr(C_BR, 4'b0000, 3'd0, 4'd1, 4'd1, 4'd0, 32'd16);
    expect_evt(1, 1, 0, 1, 28'h210, 1, 32'd0);
    do_round(8, 0);
    set_instr(C_BR, 4'b0001, 3'd0, 4'd1, 4'd1, 4'd0, 32'd16);
    expect_evt(1, 0, 0, 0, 28'd0, 1, 32'd0);
    do_round(8, 0);
    pc_v = 32'h300;
    set_instr(C_BR, 4'b0100, 3'd0, 4'd1, 4'd2, 4'd0, 32'hFFFFFFF8);
    expect_evt(1, 1, 0, 1, 28'h2F8, 1, 32'd0);
    do_round(8, 0);
    set_instr(C_BR, 4'b0110, 3'd0, 4'd1, 4'd2, 4'd0, 32'hFFFFFFF8);
    expect_evt(1, 0, 0, 0, 28'd0, 1, 32'd0);
    do_round(8, 0);

    alu(C_ALUI, 4'b0000, 4'd0, 4'd0, 4'd2, 32'h100, 32'h100);
    pc_v = 32'h400; npc_v = 32'h404;
    set_instr(C_JALR, 4'b0000, 3'd0, 4'd2, 4'd0, 4'd1, 32'd7);
    expect_evt(1, 1, 0, 1, 28'h106, 1, 32'h404);
    do_round(8, 0);
    pc_v = 32'h500; npc_v = 32'h504;
    set_instr(C_JAL, 4'b0000, 3'd0, 4'd0, 4'd0, 4'd12, 32'h20);
    expect_evt(1, 1, 0, 1, 28'h520, 1, 32'h504);
    do_round(8, 0);
    pc_v = 32'd0; npc_v = 32'd4;

    alu(C_LUI, 4'b0000, 4'd0, 4'd0, 4'd2, 32'h1000, 32'h1000);
    load(3'b000, 32'd4, 32'h5A5A5A80, 2, 32'hFFFFFF80);
    load(3'b100, 32'd4, 32'h5A5A5A80, 0, 32'h00000080);
    load(3'b001, 32'd8, 32'h12348765, 0, 32'hFFFF8765);
    load(3'b010, 32'd0, 32'h12348765, 1, 32'h12348765);

    set_instr(C_STORE, 4'b0000, 3'b010, 4'd2, 4'd1, 4'd0, 32'd0);
    stall_v = 1;
    do_round(8, 1);
    stall_v = 0;
    expect_evt(1, 0, 1, 1, 28'h1000, 1, 32'h404);
    do_round(8, 0);

    set_instr(C_ALUI, 4'b0000, 3'd0, 4'd0, 4'd0, 4'd0, 32'd7);
    expect_evt(1, 0, 0, 0, 28'd0, 0, 32'd0);
    do_round(8, 0);
    alu(C_ALUR, 4'b0000, 4'd0, 4'd0, 4'd10, 32'd0, 32'd0);

    set_instr(C_ALUR, 4'b0000, 3'd0, 4'd1, 4'd2, 4'd14, 32'd0);
    do_round(4, 1);
    alu(C_ALUI, 4'b0000, 4'd0, 4'd0, 4'd13, 32'd9, 32'd9);
    set_instr(C_LOAD, 4'b0000, 3'b000, 4'd2, 4'd0, 4'd9, 32'd0);
    expect_evt(0, 0, 1, 1, 28'h1000, 1, 32'd0);
    do_round(8, 0);
    do_round(4, 1);
    alu(C_ALUI, 4'b0000, 4'd0, 4'd0, 4'd13, 32'd9, 32'd9);

    set_instr(C_NONE, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
